time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper_if.sv | 26 ++
 rtl/time_keeper.sv | 98 +++++++++
 tb/tb_time_keeper.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/time_keeper_if.sv
// Control-button and BCD display bundle for the 24-hour time keeper.
// The slave side is the clock core; the master side drives buttons and reads the display.
interface time_keeper_if;
  logic       tick_in;
  logic       start_btn;
  logic       mode_btn;
  logic       adj_btn;
  logic [3:0] hh_t;
  logic [3:0] hh_o;
  logic [3:0] mm_t;
  logic [3:0] mm_o;
  logic [3:0] ss_t;
  logic [3:0] ss_o;
  logic [1:0] state;
  logic       day_wrap;

  modport slave (
    input  tick_in, start_btn, mode_btn, adj_btn,
    output hh_t, hh_o, mm_t, mm_o, ss_t, ss_o, state, day_wrap
  );

  modport master (
    output tick_in, start_btn, mode_btn, adj_btn,
    input  hh_t, hh_o, mm_t, mm_o, ss_t, ss_o, state, day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS BCD clock with run/pause and minute/hour set modes.
// Inputs are edge-detected against their previous sample; all outputs are registered.
module time_keeper (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_HOUR = 2'd3;

  logic       tick_p0, start_p0, mode_p0, adj_p0;
  logic       tick_ev, start_ev, mode_ev, adj_ev;
  logic [3:0] hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
  logic [1:0] state;
  logic       day_wrap;
  logic [8:0] ss_inc, mm_inc, hh_inc;

  // {carry, tens, ones} for a 00..59 field
  function automatic logic [8:0] sixty_inc(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd9) return {1'b0, t, o + 4'd1};
    if (t != 4'd5) return {1'b0, t + 4'd1, 4'd0};
    return 9'h100;
  endfunction

  // {carry, tens, ones} for a 00..23 field
  function automatic logic [8:0] hour_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) return 9'h100;
    if (o == 4'd9) return {1'b0, t + 4'd1, 4'd0};
    return {1'b0, t, o + 4'd1};
  endfunction

  assign tick_ev  = bus.tick_in   & ~tick_p0;
  assign start_ev = bus.start_btn & ~start_p0;
  assign mode_ev  = bus.mode_btn  & ~mode_p0;
  assign adj_ev   = bus.adj_btn   & ~adj_p0;

  assign ss_inc = sixty_inc(ss_t, ss_o);
  assign mm_inc = sixty_inc(mm_t, mm_o);
  assign hh_inc = hour_inc(hh_t, hh_o);

  always_ff @(posedge clk) begin
    // edge-detect stage: prev samples load even under reset so held levels never fire
    tick_p0  <= bus.tick_in;
    start_p0 <= bus.start_btn;
    mode_p0  <= bus.mode_btn;
    adj_p0   <= bus.adj_btn;
    if (rst) begin
      {hh_t, hh_o, mm_t, mm_o, ss_t, ss_o} <= 24'h000000;
      state    <= IDLE;
      day_wrap <= 1'b0;
    end else begin
      day_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            state <= RUN;
          end else if (mode_ev) begin
            state <= SET_MIN;
            ss_t  <= 4'd0;
            ss_o  <= 4'd0;
          end
        end
        RUN: begin
          if (tick_ev) begin
            {ss_t, ss_o} <= ss_inc[7:0];
            if (ss_inc[8]) begin
              {mm_t, mm_o} <= mm_inc[7:0];
              if (mm_inc[8]) begin
                {hh_t, hh_o} <= hh_inc[7:0];
                day_wrap     <= hh_inc[8];
              end
            end
          end
          if (start_ev) state <= IDLE;
        end
        SET_MIN: begin
          if (adj_ev)  {mm_t, mm_o} <= mm_inc[7:0];
          if (mode_ev) state <= SET_HOUR;
        end
        default: begin
          if (adj_ev)  {hh_t, hh_o} <= hh_inc[7:0];
          if (mode_ev) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hh_t     = hh_t;
  assign bus.hh_o     = hh_o;
  assign bus.mm_t     = mm_t;
  assign bus.mm_o     = mm_o;
  assign bus.ss_t     = ss_t;
  assign bus.ss_o     = ss_o;
  assign bus.state    = state;
  assign bus.day_wrap = day_wrap;
endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random button/tick activity,
// compared every cycle against a seconds-of-day model of the clock.
module tb_time_keeper;
  logic clk = 1'b0;
  logic rst;
  time_keeper_if bus ();

  time_keeper dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: time held as seconds since midnight
  int         m_secs  = 0;
  int         m_state = 0;
  int         m_dw    = 0;
  logic [3:0] m_prev  = 4'b0000;

  logic [23:0] disp;
  assign disp = {bus.hh_t, bus.hh_o, bus.mm_t, bus.mm_o, bus.ss_t, bus.ss_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // in = {adj, mode, start, tick}
  task automatic model_update(input logic [3:0] in, input logic r);
    logic [3:0] ev;
    int h, m;
    if (r) begin
      m_prev = in; m_secs = 0; m_state = 0; m_dw = 0;
      return;
    end
    ev = in & ~m_prev;
    m_prev = in;
    m_dw = 0;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    case (m_state)
      0: begin
        if (ev[1]) m_state = 1;
        else if (ev[2]) begin m_state = 2; m_secs = m_secs - (m_secs % 60); end
      end
      1: begin
        if (ev[0]) begin
          m_secs = (m_secs + 1) % 86400;
          if (m_secs == 0) m_dw = 1;
        end
        if (ev[1]) m_state = 0;
      end
      2: begin
        if (ev[3]) m_secs = m_secs - m * 60 + ((m + 1) % 60) * 60;
        if (ev[2]) m_state = 3;
      end
      default: begin
        if (ev[3]) m_secs = m_secs - h * 3600 + ((h + 1) % 24) * 3600;
        if (ev[2]) m_state = 0;
      end
    endcase
  endtask

  task automatic step(input logic [3:0] in, input logic r);
    @(negedge clk);
    bus.tick_in   = in[0];
    bus.start_btn = in[1];
    bus.mode_btn  = in[2];
    bus.adj_btn   = in[3];
    rst = r;
    @(posedge clk);
    model_update(in, r);
    #1;
    check("state", 32'(bus.state), 32'(m_state));
    check("time", 32'(disp), 32'(to_bcd(m_secs)));
    check("day_wrap", 32'(bus.day_wrap), 32'(m_dw));
  endtask

  task automatic pulse(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step(b, 1'b0);
      step(4'b0000, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
  endtask

  localparam logic [3:0] TICK  = 4'b0001;
  localparam logic [3:0] START = 4'b0010;
  localparam logic [3:0] MODE  = 4'b0100;
  localparam logic [3:0] ADJ   = 4'b1000;

  initial begin
    logic [3:0] lvl;
    logic       r;
    int         dw_seen;
    rst = 1'b1;
    bus.tick_in = 0; bus.start_btn = 0; bus.mode_btn = 0; bus.adj_btn = 0;

    do_reset();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_time", 32'(disp), 32'h000000);
    check("rst_dw", 32'(bus.day_wrap), 32'd0);

    // start then three seconds
    pulse(START, 1);
    pulse(TICK, 3);
    check("run3_state", 32'(bus.state), 32'd1);
    check("run3_time", 32'(disp), 32'h000003);

    // tick alone must update on the first cycle it is seen high
    step(TICK, 1'b0);
    check("tick_latency", 32'(disp), 32'h000004);
    step(4'b0000, 1'b0);

    // set 23:59, run to 23:59:58, then cross midnight
    do_reset();
    pulse(MODE, 1);
    pulse(ADJ, 59);
    pulse(MODE, 1);
    pulse(ADJ, 23);
    pulse(MODE, 1);
    check("set_2359", 32'(disp), 32'h235900);
    pulse(START, 1);
    pulse(TICK, 58);
    check("pre_wrap", 32'(disp), 32'h235958);
    pulse(TICK, 1);
    check("at_2359", 32'(disp), 32'h235959);
    step(TICK, 1'b0);
    check("wrap_time", 32'(disp), 32'h000000);
    check("wrap_pulse", 32'(bus.day_wrap), 32'd1);
    step(4'b0000, 1'b0);
    check("wrap_one_cycle", 32'(bus.day_wrap), 32'd0);

    // set-mode wraps and ignored ticks
    do_reset();
    pulse(START, 1); pulse(TICK, 7); pulse(START, 1);
    pulse(MODE, 1);
    check("set_min_ss_clr", 32'(disp), 32'h000000);
    pulse(ADJ, 61);
    pulse(TICK, 3);
    check("set_min", 32'(disp), 32'h000100);
    pulse(MODE, 1);
    pulse(ADJ, 25);
    pulse(TICK | START, 2);
    check("set_hour", 32'(disp), 32'h010100);
    check("set_hour_state", 32'(bus.state), 32'd3);
    pulse(MODE, 1);
    check("set_done_state", 32'(bus.state), 32'd0);

    // simultaneous tick and start in RUN
    do_reset();
    pulse(START, 1);
    pulse(TICK, 9);
    step(TICK | START, 1'b0);
    check("tick_start_time", 32'(disp), 32'h000010);
    check("tick_start_state", 32'(bus.state), 32'd0);
    step(4'b0000, 1'b0);
    pulse(TICK, 3);
    check("idle_ticks", 32'(disp), 32'h000010);

    // start and mode together in IDLE: start wins
    pulse(START | MODE, 1);
    check("start_prio", 32'(bus.state), 32'd1);
    pulse(START, 1);

    // start held through reset produces no event
    step(START, 1'b1);
    step(START, 1'b1);
    step(START, 1'b0);
    step(START, 1'b0);
    check("held_start", 32'(bus.state), 32'd0);
    step(4'b0000, 1'b0);

    // reset mid-count at 12:34:56
    pulse(MODE, 1); pulse(ADJ, 34); pulse(MODE, 1); pulse(ADJ, 12); pulse(MODE, 1);
    pulse(START, 1); pulse(TICK, 56);
    check("pre_abort", 32'(disp), 32'h123456);
    step(TICK, 1'b1);
    check("abort_time", 32'(disp), 32'h000000);
    check("abort_state", 32'(bus.state), 32'd0);
    step(4'b0000, 1'b0);

    // random activity against the model
    lvl = 4'b0000;
    dw_seen = 0;
    for (int i = 0; i < 6000; i++) begin
      lvl[0] = ($urandom_range(0, 1) == 0) ? ~lvl[0] : lvl[0];
      for (int b = 1; b < 4; b++)
        if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
      r = ($urandom_range(0, 999) == 0);
      step(lvl, r);
      if (m_dw != 0) dw_seen++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
